// File: rtl/cr16_exec_ctrl.sv
// Run/debug sequencer for the CR16 core: warm-up wait, free-run, single-step,
// external halt and PC breakpoint, all driving the core enable from one FSM.
module cr16_exec_ctrl #(
    parameter logic [15:0] P_COLD_CLK_CYCLES = 16'd1,
    parameter logic [15:0] P_MAX_PC          = 16'd20,
    parameter logic [15:0] P_STEP_TIMEOUT    = 16'd8,
    parameter logic        P_START_RUNNING   = 1'b1
) (
    input  logic        I_CLK,
    input  logic        I_NRESET,
    input  logic        I_RUN,
    input  logic        I_STEP,
    input  logic        I_HALT,
    input  logic        I_BREAK_EN,
    input  logic [15:0] I_BREAK_PC,
    input  logic [15:0] I_PC,
    output logic        O_CR16_ENABLE,
    output logic [1:0]  O_STATE,
    output logic [2:0]  O_HALT_CAUSE,
    output logic        O_DONE,
    output logic [15:0] O_INSTR_COUNT
);

    localparam logic [1:0] ST_WARMUP = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [15:0] warm_cnt;
    logic [15:0] step_cnt;
    logic [15:0] step_pc;
    logic [15:0] pc_prev;
    logic [15:0] instr_count;
    logic [2:0]  halt_cause;
    logic        run_prev;
    logic        step_prev;
    logic        bp_mask;

    logic done;
    logic bp;
    logic stop;
    logic run_edge;
    logic step_edge;
    logic pc_changed;
    logic step_exit;
    logic leave_halt;
    logic enable;

    // Control inputs are plain levels sampled every cycle; there is no
    // valid/ready handshake, only rising-edge detection on I_RUN and I_STEP.
    assign done       = (I_PC > P_MAX_PC);
    assign bp         = I_BREAK_EN & (I_PC == I_BREAK_PC) & ~bp_mask;
    assign stop       = done | bp | I_HALT;
    assign run_edge   = I_RUN & ~run_prev;
    assign step_edge  = I_STEP & ~step_prev;
    assign pc_changed = (I_PC != pc_prev);
    assign step_exit  = (I_PC != step_pc) | done | (step_cnt == P_STEP_TIMEOUT - 16'd1);
    assign leave_halt = (state == ST_HALT) & ~done & (step_edge | (run_edge & ~I_HALT));

    always_comb begin
        enable    = 1'b0;
        state_nxt = state;
        case (state)
            ST_WARMUP: begin
                if (warm_cnt == P_COLD_CLK_CYCLES)
                    state_nxt = P_START_RUNNING ? ST_RUN : ST_HALT;
            end
            ST_RUN: begin
                // Zero-latency stop so the core never executes past a stop condition.
                enable = ~stop;
                if (stop)
                    state_nxt = ST_HALT;
            end
            ST_STEP: begin
                enable = ~done;
                if (step_exit)
                    state_nxt = ST_HALT;
            end
            default: begin
                if (leave_halt)
                    state_nxt = step_edge ? ST_STEP : ST_RUN;
            end
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state       <= ST_WARMUP;
            warm_cnt    <= 16'd0;
            step_cnt    <= 16'd0;
            step_pc     <= 16'd0;
            pc_prev     <= 16'd0;
            instr_count <= 16'd0;
            halt_cause  <= 3'b000;
            run_prev    <= 1'b0;
            step_prev   <= 1'b0;
            bp_mask     <= 1'b0;
        end else begin
            state     <= state_nxt;
            run_prev  <= I_RUN;
            step_prev <= I_STEP;
            pc_prev   <= I_PC;

            if (state == ST_WARMUP && warm_cnt != P_COLD_CLK_CYCLES)
                warm_cnt <= warm_cnt + 16'd1;

            if (state == ST_RUN && stop)
                halt_cause <= {I_HALT, bp, done};
            else if (state == ST_STEP && step_exit)
                halt_cause <= {1'b1, 1'b0, done};
            else if (leave_halt)
                halt_cause <= 3'b000;

            if (leave_halt && step_edge) begin
                step_pc  <= I_PC;
                step_cnt <= 16'd0;
            end else if (state == ST_STEP && !step_exit) begin
                step_cnt <= step_cnt + 16'd1;
            end

            // Resuming from a breakpoint must not re-hit the same PC.
            if (leave_halt && I_PC == I_BREAK_PC)
                bp_mask <= 1'b1;
            else if (pc_changed)
                bp_mask <= 1'b0;

            if (enable && pc_changed && instr_count != 16'hFFFF)
                instr_count <= instr_count + 16'd1;
        end
    end

    assign O_CR16_ENABLE = enable;
    assign O_STATE       = state;
    assign O_HALT_CAUSE  = halt_cause;
    assign O_DONE        = done;
    assign O_INSTR_COUNT = instr_count;

endmodule

// File: tb/tb_cr16_exec_ctrl.sv
// Directed bench for cr16_exec_ctrl: the driver pushes hand-computed output
// snapshots per cycle, a negedge monitor pops and compares them.
module tb_cr16_exec_ctrl;

    localparam int W = 23;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        step;
    logic        halt;
    logic        break_en;
    logic [15:0] break_pc;
    logic [15:0] pc;
    logic        cr16_enable;
    logic [1:0]  state;
    logic [2:0]  halt_cause;
    logic        done;
    logic [15:0] instr_count;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    string        exp_name_q[$];

    int cyc;
    int n_checks;
    int n_fail;

    cr16_exec_ctrl dut (
        .I_CLK         (clk),
        .I_NRESET      (rst_n),
        .I_RUN         (run),
        .I_STEP        (step),
        .I_HALT        (halt),
        .I_BREAK_EN    (break_en),
        .I_BREAK_PC    (break_pc),
        .I_PC          (pc),
        .O_CR16_ENABLE (cr16_enable),
        .O_STATE       (state),
        .O_HALT_CAUSE  (halt_cause),
        .O_DONE        (done),
        .O_INSTR_COUNT (instr_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic drv(input logic rn, input logic [15:0] p, input logic r,
                       input logic s, input logic h);
        @(posedge clk);
        #1;
        rst_n = rn;
        pc    = p;
        run   = r;
        step  = s;
        halt  = h;
    endtask

    task automatic expect_out(input string name, input logic en, input logic [1:0] st,
                              input logic [2:0] cause, input logic dn, input logic [15:0] cnt);
        exp_q.push_back({en, st, cause, dn, cnt});
        exp_cyc_q.push_back(cyc);
        exp_name_q.push_back(name);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] expv;
        string        nm;
        int           ec;
        act = {cr16_enable, state, halt_cause, done, instr_count};
        while (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            expv = exp_q.pop_front();
            ec   = exp_cyc_q.pop_front();
            nm   = exp_name_q.pop_front();
            n_checks++;
            if (ec != cyc) begin
                n_fail++;
                $display("FAIL %s: entry for cycle %0d seen at cycle %0d", nm, ec, cyc);
            end else if (act !== expv) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: actual en=%b st=%0d cause=%b done=%b cnt=%0d, required en=%b st=%0d cause=%b done=%b cnt=%0d",
                         nm, cyc, act[22], act[21:20], act[19:17], act[16], act[15:0],
                         expv[22], expv[21:20], expv[19:17], expv[16], expv[15:0]);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        pc       = 16'd0;
        run      = 1'b0;
        step     = 1'b0;
        halt     = 1'b0;
        break_en = 1'b1;
        break_pc = 16'd5;

        drv(0, 0, 0, 0, 0); expect_out("reset", 0, 0, 3'b000, 0, 0);

        // warm-up then free run, breakpoint at PC 5
        drv(1, 0, 0, 0, 0); expect_out("warmup0", 0, 0, 3'b000, 0, 0);
        drv(1, 1, 0, 0, 0); expect_out("warmup1", 0, 0, 3'b000, 0, 0);
        drv(1, 2, 0, 0, 0); expect_out("run_pc2", 1, 1, 3'b000, 0, 0);
        drv(1, 3, 0, 0, 0); expect_out("run_pc3", 1, 1, 3'b000, 0, 1);
        drv(1, 4, 0, 0, 0); expect_out("run_pc4", 1, 1, 3'b000, 0, 2);
        drv(1, 5, 0, 0, 0); expect_out("bp_stop", 0, 1, 3'b000, 0, 3);
        drv(1, 5, 0, 0, 0); expect_out("bp_halt", 0, 3, 3'b010, 0, 3);
        drv(1, 5, 1, 0, 0); expect_out("run_edge", 0, 3, 3'b010, 0, 3);
        drv(1, 5, 1, 0, 0); expect_out("bp_masked", 1, 1, 3'b000, 0, 3);
        drv(1, 6, 1, 0, 0); expect_out("run_pc6", 1, 1, 3'b000, 0, 3);

        // external halt at PC 7, then a single step that advances after 3 cycles
        drv(1, 7, 0, 0, 1); expect_out("ext_halt", 0, 1, 3'b000, 0, 4);
        drv(1, 7, 0, 0, 0); expect_out("halted_pc7", 0, 3, 3'b100, 0, 4);
        drv(1, 7, 0, 1, 0); expect_out("step_edge", 0, 3, 3'b100, 0, 4);
        drv(1, 7, 0, 1, 0); expect_out("step_c1", 1, 2, 3'b000, 0, 4);
        drv(1, 7, 0, 1, 0); expect_out("step_c2", 1, 2, 3'b000, 0, 4);
        drv(1, 8, 0, 1, 0); expect_out("step_c3", 1, 2, 3'b000, 0, 4);
        drv(1, 8, 0, 0, 0); expect_out("step_done", 0, 3, 3'b100, 0, 5);

        // run and step edges together -> STEP; PC frozen -> timeout after 8 cycles
        drv(1, 8, 1, 1, 0); expect_out("both_edges", 0, 3, 3'b100, 0, 5);
        for (int i = 0; i < 8; i++) begin
            drv(1, 8, 1, 1, 0); expect_out($sformatf("step_to_%0d", i), 1, 2, 3'b000, 0, 5);
        end
        drv(1, 8, 0, 0, 0); expect_out("step_timeout", 0, 3, 3'b100, 0, 5);

        // step again, then asynchronous reset while in STEP
        drv(1, 8, 0, 1, 0); expect_out("step2_edge", 0, 3, 3'b100, 0, 5);
        drv(1, 8, 0, 1, 0); expect_out("step2_c1", 1, 2, 3'b000, 0, 5);
        drv(0, 8, 0, 0, 0); expect_out("async_reset", 0, 0, 3'b000, 0, 0);

        // fresh run climbing past the PC limit, no breakpoint
        break_en = 1'b0;
        drv(1, 10, 0, 0, 0); expect_out("re_warmup0", 0, 0, 3'b000, 0, 0);
        drv(1, 10, 0, 0, 0); expect_out("re_warmup1", 0, 0, 3'b000, 0, 0);
        drv(1, 10, 0, 0, 0); expect_out("re_run_pc10", 1, 1, 3'b000, 0, 0);
        for (int p = 11; p <= 20; p++) begin
            drv(1, 16'(p), 0, 0, 0);
            expect_out($sformatf("climb_pc%0d", p), 1, 1, 3'b000, 0, 16'(p - 11));
        end
        drv(1, 21, 0, 0, 0); expect_out("limit_stop", 0, 1, 3'b000, 1, 10);
        drv(1, 21, 1, 1, 0); expect_out("done_halt", 0, 3, 3'b001, 1, 10);
        drv(1, 21, 0, 0, 0); expect_out("done_ignore1", 0, 3, 3'b001, 1, 10);
        drv(1, 21, 0, 1, 0); expect_out("done_ignore2", 0, 3, 3'b001, 1, 10);
        drv(1, 21, 1, 0, 0); expect_out("done_ignore3", 0, 3, 3'b001, 1, 10);
        drv(1, 21, 0, 0, 0); expect_out("done_stays", 0, 3, 3'b001, 1, 10);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
